// File: rtl/bell_round_ctrl_if.sv
// Bundle of keypad/card inputs and score/status outputs for bell_round_ctrl.
//   master : keypad decoder / stimulus side, drives bell and the card pair and
//            reads back scores and round status.
//   slave  : the round controller itself.
// Protocol note: there is no valid/ready pair. A round starts on a rising
// edge of any bell bit while the controller is idle (busy = 0). The card
// fields and reward are sampled on that same clock edge only. round_done
// pulses for one cycle when the scores for that round are visible. No new
// round starts until every bell key has been released.
interface bell_round_ctrl_if #(
    parameter int NPLAYERS = 2,
    parameter int SCORE_W  = 8,
    parameter int NUM_W    = 3,
    parameter int COLOR_W  = 2
);
    logic [NPLAYERS-1:0]         bell;
    logic                        card_valid;
    logic [COLOR_W-1:0]          c1;
    logic [COLOR_W-1:0]          c2;
    logic [NUM_W-1:0]            n1;
    logic [NUM_W-1:0]            n2;
    logic [SCORE_W-1:0]          reward;
    logic [NPLAYERS*SCORE_W-1:0] score;
    logic                        busy;
    logic                        round_done;
    logic [NPLAYERS-1:0]         last_who;
    logic                        last_right;
    logic                        winner_valid;
    logic [2:0]                  winner_id;
    logic [1:0]                  dbg_state;   // FSM state, for observation only

    modport master (
        output bell, card_valid, c1, c2, n1, n2, reward,
        input  score, busy, round_done, last_who, last_right,
               winner_valid, winner_id, dbg_state
    );

    modport slave (
        input  bell, card_valid, c1, c2, n1, n2, reward,
        output score, busy, round_done, last_who, last_right,
               winner_valid, winner_id, dbg_state
    );
endinterface

// File: rtl/bell_round_ctrl.sv
// N-player bell-round controller: detects bell presses, arbitrates them with
// a rotating priority, judges the latched card pair, applies a saturating
// reward or penalty to per-player signed scores and flags a winner by margin.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-low reset
//   bus  : bell_round_ctrl_if.slave (bell/card inputs, score/status outputs,
//          dbg_state exposes the FSM state: 0 IDLE, 1 JUDGE, 2 APPLY, 3 LOCK)
module bell_round_ctrl #(
    parameter int NPLAYERS   = 2,
    parameter int SCORE_W    = 8,
    parameter int NUM_W      = 3,
    parameter int COLOR_W    = 2,
    parameter int TARGET     = 5,
    parameter int PENALTY    = 1,
    parameter int WIN_MARGIN = 50
) (
    input  logic clk,
    input  logic rst,
    bell_round_ctrl_if.slave bus
);

    // Wide headroom for score arithmetic so saturation never sees a wrapped value.
    localparam int EW = SCORE_W + 12;
    // Width used for the winner comparison.
    localparam int WW = SCORE_W + 2;

    localparam logic signed [EW-1:0] SMAX     = EW'((2 ** (SCORE_W - 1)) - 1);
    localparam logic signed [EW-1:0] SMIN     = ~SMAX;
    localparam logic signed [EW-1:0] PEN_ONE  = EW'(PENALTY);
    localparam logic signed [EW-1:0] PEN_ALL  = EW'(PENALTY * (NPLAYERS - 1));
    localparam logic signed [WW-1:0] MARG     = WW'(WIN_MARGIN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        JUDGE = 2'd1,
        APPLY = 2'd2,
        LOCK  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NPLAYERS-1:0]  bell_q, bell_d;
    logic [NPLAYERS-1:0]  blk_q, blk_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [NPLAYERS-1:0]  who_q, who_d;
    logic                 cv_q, cv_d;
    logic [COLOR_W-1:0]   c1_q, c1_d, c2_q, c2_d;
    logic [NUM_W-1:0]     n1_q, n1_d, n2_q, n2_d;
    logic [SCORE_W-1:0]   reward_q, reward_d;
    logic                 right_q, right_d;
    logic [SCORE_W-1:0]   score_q [NPLAYERS];
    logic [SCORE_W-1:0]   score_d [NPLAYERS];
    logic                 rd_q, rd_d;
    logic                 wv_q, wv_d;
    logic [2:0]           wid_q, wid_d;

    logic [NPLAYERS-1:0]  press;
    logic [NPLAYERS-1:0]  grant;
    logic [2:0]           grant_idx;
    logic                 found;
    logic                 judge_right;
    logic [NUM_W:0]       num_sum;

    function automatic logic signed [EW-1:0] ext_s(input logic [SCORE_W-1:0] s);
        return {{(EW-SCORE_W){s[SCORE_W-1]}}, s};
    endfunction

    function automatic logic signed [WW-1:0] ext_w(input logic [SCORE_W-1:0] s);
        return {{(WW-SCORE_W){s[SCORE_W-1]}}, s};
    endfunction

    function automatic logic [SCORE_W-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SMAX)      return SMAX[SCORE_W-1:0];
        else if (v < SMIN) return SMIN[SCORE_W-1:0];
        else               return v[SCORE_W-1:0];
    endfunction

    // blk_q masks keys that were already down when reset was released; a bit
    // clears once that key is seen low, so only a fresh press counts.
    assign press = bus.bell & ~bell_q & ~blk_q;

    // Rotating-priority search starting at ptr_q.
    always_comb begin
        int idx;
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NPLAYERS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NPLAYERS) idx = idx - NPLAYERS;
            if (!found && press[idx]) begin
                found     = 1'b1;
                grant_idx = 3'(idx);
            end
        end
        grant = found ? (NPLAYERS'(1) << grant_idx) : '0;
    end

    // Sum carried one bit wider so e.g. 7+6 cannot wrap onto the target.
    always_comb begin
        num_sum = {1'b0, n1_q} + {1'b0, n2_q};
        if (!cv_q)
            judge_right = 1'b0;
        else if (c1_q == c2_q)
            judge_right = (32'(num_sum) == TARGET);
        else
            judge_right = (32'(n1_q) == TARGET) || (32'(n2_q) == TARGET);
    end

    always_comb begin
        logic signed [EW-1:0] v;
        state_d  = state_q;
        bell_d   = bus.bell;
        blk_d    = blk_q & bus.bell;
        ptr_d    = ptr_q;
        who_d    = who_q;
        cv_d     = cv_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        n1_d     = n1_q;
        n2_d     = n2_q;
        reward_d = reward_q;
        right_d  = right_q;
        rd_d     = 1'b0;
        v        = '0;
        for (int i = 0; i < NPLAYERS; i++) score_d[i] = score_q[i];

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = JUDGE;
                    who_d    = grant;
                    ptr_d    = (grant_idx == 3'(NPLAYERS - 1)) ? 3'd0 : grant_idx + 3'd1;
                    cv_d     = bus.card_valid;
                    c1_d     = bus.c1;
                    c2_d     = bus.c2;
                    n1_d     = bus.n1;
                    n2_d     = bus.n2;
                    reward_d = bus.reward;
                end
            end
            JUDGE: begin
                right_d = judge_right;
                state_d = APPLY;
            end
            APPLY: begin
                for (int i = 0; i < NPLAYERS; i++) begin
                    if (who_q[i])
                        v = right_q ? ext_s(score_q[i]) + {{(EW-SCORE_W){1'b0}}, reward_q}
                                    : ext_s(score_q[i]) - PEN_ALL;
                    else
                        v = right_q ? ext_s(score_q[i]) : ext_s(score_q[i]) + PEN_ONE;
                    score_d[i] = sat(v);
                end
                rd_d    = 1'b1;
                state_d = LOCK;
            end
            LOCK: begin
                if (bus.bell == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Winner: the unique player leading every other by more than the margin.
    always_comb begin
        logic       lead;
        logic [3:0] cnt;
        wv_d  = 1'b0;
        wid_d = '0;
        cnt   = '0;
        lead  = 1'b0;
        for (int i = 0; i < NPLAYERS; i++) begin
            lead = 1'b1;
            for (int j = 0; j < NPLAYERS; j++) begin
                if (j != i && !(ext_w(score_q[i]) > ext_w(score_q[j]) + MARG))
                    lead = 1'b0;
            end
            if (lead) begin
                cnt   = cnt + 4'd1;
                wid_d = 3'(i);
            end
        end
        if (cnt == 4'd1) begin
            wv_d = 1'b1;
        end else begin
            wid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            bell_q   <= '0;
            blk_q    <= '1;
            ptr_q    <= '0;
            who_q    <= '0;
            cv_q     <= 1'b0;
            c1_q     <= '0;
            c2_q     <= '0;
            n1_q     <= '0;
            n2_q     <= '0;
            reward_q <= '0;
            right_q  <= 1'b0;
            rd_q     <= 1'b0;
            wv_q     <= 1'b0;
            wid_q    <= '0;
            for (int i = 0; i < NPLAYERS; i++) score_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            bell_q   <= bell_d;
            blk_q    <= blk_d;
            ptr_q    <= ptr_d;
            who_q    <= who_d;
            cv_q     <= cv_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            n1_q     <= n1_d;
            n2_q     <= n2_d;
            reward_q <= reward_d;
            right_q  <= right_d;
            rd_q     <= rd_d;
            wv_q     <= wv_d;
            wid_q    <= wid_d;
            for (int i = 0; i < NPLAYERS; i++) score_q[i] <= score_d[i];
        end
    end

    for (genvar g = 0; g < NPLAYERS; g++) begin : g_score
        assign bus.score[g*SCORE_W +: SCORE_W] = score_q[g];
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.round_done   = rd_q;
    assign bus.last_who     = who_q;
    assign bus.last_right   = right_q;
    assign bus.winner_valid = wv_q;
    assign bus.winner_id    = wid_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_bell_round_ctrl.sv
// Directed bench for bell_round_ctrl: a table of rounds with hand-computed
// cumulative scores, then hand-written sequences for negative scores,
// saturation/winner, held keys and reset during a round.
module tb_bell_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bell_round_ctrl_if #(.NPLAYERS(2), .SCORE_W(8), .NUM_W(3), .COLOR_W(2)) bus ();

    bell_round_ctrl #(
        .NPLAYERS(2), .SCORE_W(8), .NUM_W(3), .COLOR_W(2),
        .TARGET(5), .PENALTY(1), .WIN_MARGIN(50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] bell;
        logic       cv;
        logic [1:0] c1;
        logic [1:0] c2;
        logic [2:0] n1;
        logic [2:0] n2;
        logic [7:0] reward;
        logic [1:0] exp_who;
        logic       exp_right;
        logic [7:0] exp_s0;
        logic [7:0] exp_s1;
    } vec_t;

    vec_t vecs [9];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b0;
        bus.bell = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_cards(input logic cv, input logic [1:0] c1, input logic [1:0] c2,
                             input logic [2:0] n1, input logic [2:0] n2, input logic [7:0] rw);
        bus.card_valid = cv;
        bus.c1         = c1;
        bus.c2         = c2;
        bus.n1         = n1;
        bus.n2         = n2;
        bus.reward     = rw;
    endtask

    // Press, count cycles to round_done (bounded), release, wait for idle.
    task automatic do_round(input string name, input logic [1:0] pat);
        int lat;
        logic rd_after;
        @(negedge clk);
        bus.bell = pat;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.round_done) begin
                lat = i;
                break;
            end
        end
        bus.bell = '0;
        @(negedge clk);
        rd_after = bus.round_done;
        for (int i = 0; i < 10 && bus.busy; i++) @(negedge clk);
        check({name, "_latency"}, 32'(lat), 32'd3);
        check({name, "_pulse_end"}, 32'(rd_after), 32'd0);
        check({name, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pulses;
        logic busy_seen;

        //             bell  cv  c1 c2 n1 n2 rw    who   right s0      s1
        vecs[0] = '{2'b01, 1'b1, 2'd1, 2'd1, 3'd2, 3'd3, 8'd10, 2'b01, 1'b1, 8'd10, 8'd0};
        vecs[1] = '{2'b10, 1'b1, 2'd1, 2'd2, 3'd0, 3'd5, 8'd7,  2'b10, 1'b1, 8'd10, 8'd7};
        vecs[2] = '{2'b11, 1'b1, 2'd2, 2'd2, 3'd4, 3'd1, 8'd3,  2'b01, 1'b1, 8'd13, 8'd7};
        vecs[3] = '{2'b11, 1'b1, 2'd0, 2'd3, 3'd5, 3'd0, 8'd2,  2'b10, 1'b1, 8'd13, 8'd9};
        vecs[4] = '{2'b01, 1'b1, 2'd2, 2'd2, 3'd1, 3'd1, 8'd9,  2'b01, 1'b0, 8'd12, 8'd10};
        vecs[5] = '{2'b10, 1'b0, 2'd1, 2'd1, 3'd2, 3'd3, 8'd9,  2'b10, 1'b0, 8'd13, 8'd9};
        vecs[6] = '{2'b01, 1'b1, 2'd3, 2'd3, 3'd7, 3'd6, 8'd9,  2'b01, 1'b0, 8'd12, 8'd10};
        vecs[7] = '{2'b10, 1'b1, 2'd0, 2'd1, 3'd5, 3'd5, 8'd1,  2'b10, 1'b1, 8'd12, 8'd11};
        vecs[8] = '{2'b01, 1'b1, 2'd1, 2'd2, 3'd2, 3'd3, 8'd9,  2'b01, 1'b0, 8'd11, 8'd12};

        bus.bell = '0;
        set_cards(1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 8'd0);
        apply_reset();

        check("rst_score", 32'(bus.score), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_round_done", 32'(bus.round_done), 32'd0);
        check("rst_last_who", 32'(bus.last_who), 32'd0);
        check("rst_last_right", 32'(bus.last_right), 32'd0);
        check("rst_winner_valid", 32'(bus.winner_valid), 32'd0);
        check("rst_winner_id", 32'(bus.winner_id), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);

        for (int i = 0; i < 9; i++) begin
            set_cards(vecs[i].cv, vecs[i].c1, vecs[i].c2, vecs[i].n1, vecs[i].n2, vecs[i].reward);
            do_round($sformatf("vec%0d", i), vecs[i].bell);
            check($sformatf("vec%0d_who", i), 32'(bus.last_who), 32'(vecs[i].exp_who));
            check($sformatf("vec%0d_right", i), 32'(bus.last_right), 32'(vecs[i].exp_right));
            check($sformatf("vec%0d_s0", i), 32'(bus.score[7:0]), 32'(vecs[i].exp_s0));
            check($sformatf("vec%0d_s1", i), 32'(bus.score[15:8]), 32'(vecs[i].exp_s1));
        end
        check("table_no_winner", 32'(bus.winner_valid), 32'd0);

        // Wrong press from zero goes negative; the other player gains.
        apply_reset();
        set_cards(1'b1, 2'd1, 2'd1, 3'd1, 3'd1, 8'd0);
        do_round("neg", 2'b01);
        check("neg_s0", 32'(bus.score[7:0]), 32'hFF);
        check("neg_s1", 32'(bus.score[15:8]), 32'd1);

        // Saturation at +127 and a player-0 win.
        apply_reset();
        set_cards(1'b1, 2'd1, 2'd1, 3'd2, 3'd3, 8'd120);
        do_round("sat_a", 2'b01);
        check("sat_a_s0", 32'(bus.score[7:0]), 32'd120);
        check("sat_a_wv", 32'(bus.winner_valid), 32'd1);
        check("sat_a_wid", 32'(bus.winner_id), 32'd0);
        bus.reward = 8'd20;
        do_round("sat_b", 2'b01);
        check("sat_b_s0", 32'(bus.score[7:0]), 32'd127);
        check("sat_b_wv", 32'(bus.winner_valid), 32'd1);

        // Lead exactly equal to the margin is not a win; then player 1 wins.
        apply_reset();
        set_cards(1'b1, 2'd1, 2'd1, 3'd2, 3'd3, 8'd50);
        do_round("margin", 2'b01);
        check("margin_s0", 32'(bus.score[7:0]), 32'd50);
        check("margin_wv", 32'(bus.winner_valid), 32'd0);
        bus.reward = 8'd200;
        do_round("p1win", 2'b10);
        check("p1win_s1", 32'(bus.score[15:8]), 32'd127);
        check("p1win_wv", 32'(bus.winner_valid), 32'd1);
        check("p1win_wid", 32'(bus.winner_id), 32'd1);

        // Held key gives one round; a new press during LOCK is ignored.
        apply_reset();
        set_cards(1'b1, 2'd1, 2'd1, 3'd2, 3'd3, 8'd1);
        pulses = 0;
        @(negedge clk);
        bus.bell = 2'b01;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.round_done) pulses++;
            if (i == 8) bus.bell = 2'b11;
        end
        bus.bell = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.round_done) pulses++;
        end
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_s0", 32'(bus.score[7:0]), 32'd1);
        check("held_s1", 32'(bus.score[15:8]), 32'd0);
        check("held_idle", 32'(bus.busy), 32'd0);

        // Reset during APPLY discards the round; held key at release is not a press.
        bus.reward = 8'd4;
        @(negedge clk);
        bus.bell = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check("mid_in_apply", 32'(bus.dbg_state), 32'd2);
        rst = 1'b0;
        @(negedge clk);
        check("mid_score", 32'(bus.score), 32'd0);
        check("mid_state", 32'(bus.dbg_state), 32'd0);
        check("mid_round_done", 32'(bus.round_done), 32'd0);
        rst = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.busy || bus.round_done) busy_seen = 1'b1;
        end
        check("mid_held_ignored", 32'(busy_seen), 32'd0);
        bus.bell = 2'b00;
        repeat (2) @(negedge clk);
        do_round("mid_after", 2'b01);
        check("mid_after_s0", 32'(bus.score[7:0]), 32'd4);
        check("mid_after_s1", 32'(bus.score[15:8]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
